// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: DMType codes, FSM states,
// the latched request record and the byte-enable / write-data helpers.
package lsu_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  dmtype;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
  } lsu_req_t;

  // Legal DMType and naturally aligned for its size.
  function automatic logic lsu_legal(input logic [2:0] dm, input logic [1:0] off);
    case (dm)
      DM_WORD:             lsu_legal = (off == 2'b00);
      DM_HALF, DM_HALF_U:  lsu_legal = ~off[0];
      DM_BYTE, DM_BYTE_U:  lsu_legal = 1'b1;
      default:             lsu_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] dm, input logic [1:0] off);
    case (dm)
      DM_HALF, DM_HALF_U:  lsu_be = 4'b0011 << {off[1], 1'b0};
      DM_BYTE, DM_BYTE_U:  lsu_be = 4'b0001 << off;
      default:             lsu_be = 4'b1111;
    endcase
  endfunction

  // Replicate the LSB-justified store data onto every lane it may land in.
  function automatic logic [31:0] lsu_wdata(input logic [2:0] dm, input logic [31:0] wd);
    case (dm)
      DM_HALF, DM_HALF_U:  lsu_wdata = {2{wd[15:0]}};
      DM_BYTE, DM_BYTE_U:  lsu_wdata = {4{wd[7:0]}};
      default:             lsu_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_fsm_if.sv
// Word-wide req/ack memory bus between the LSU (master) and memory (slave).
interface lsu_fsm_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_load_ext.sv
// Load lane select plus sign/zero extension of a raw bus word.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [2:0]  dmtype,
  output logic [31:0] ext
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    lane8  = raw[8*off +: 8];
    lane16 = off[1] ? raw[31:16] : raw[15:0];
    case (dmtype)
      DM_BYTE:   ext = {{24{lane8[7]}}, lane8};
      DM_BYTE_U: ext = {24'd0, lane8};
      DM_HALF:   ext = {{16{lane16[15]}}, lane16};
      DM_HALF_U: ext = {16'd0, lane16};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_fsm.sv
// Load/store unit: one decoded access -> one byte-enabled req/ack bus transfer.
// Define LSU_TIMEOUT_EN to abort BUSY after TIMEOUT cycles without bus_ack.
module lsu_fsm
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [2:0]        DMType,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              fault,
  lsu_fsm_if.master         bus
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [31:0]       ext_data;
  logic              access;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  lsu_load_ext u_ext (
    .raw    (bus.bus_rdata),
    .off    (req_q.off),
    .dmtype (req_q.dmtype),
    .ext    (ext_data)
  );

  assign access = mem_req & (MemWrite | MemRead);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    stall   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = (state_q == BUSY) ? cnt_q + 8'd1 : 8'd0;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          if (lsu_legal(DMType, addr[1:0])) begin
            stall        = 1'b1;
            state_d      = BUSY;
            req_d.we     = MemWrite;
            req_d.dmtype = DMType;
            req_d.off    = addr[1:0];
            req_d.be     = lsu_be(DMType, addr[1:0]);
            req_d.wdata  = lsu_wdata(DMType, wdata);
            addr_d       = {addr[ADDR_W-1:2], 2'b00};
          end else begin
            // Faulting access: no bus traffic, pipeline keeps moving.
            fault_d = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          state_d = DONE;
          if (!req_q.we) begin
            rdata_d = ext_data;
            valid_d = 1'b1;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = DONE;
          fault_d = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // valid_q is only set on a load ack, so it is high exactly in that DONE cycle.
  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign fault       = fault_q;

  assign bus.bus_req   = (state_q == BUSY);
  assign bus.bus_we    = req_q.we;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = req_q.be;
  assign bus.bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_lsu_fsm.sv
module tb_lsu_fsm;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [2:0]  DMType = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;

  int n_chk = 0;
  int n_err = 0;

  lsu_fsm_if #(.ADDR_W(32)) bus_if ();

  lsu_fsm #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .DMType      (DMType),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] dm, input logic [31:0] a,
                         input logic [31:0] raw, input logic [3:0] be, input logic [31:0] exp);
    tick();
    mem_req = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; DMType = dm; addr = a;
    @(negedge clk);
    chk({tag, "_accept_stall"}, stall, 1'b1);
    tick();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = raw;
    @(negedge clk);
    chk({tag, "_req"}, bus_if.bus_req, 1'b1);
    chk({tag, "_be"}, bus_if.bus_be, be);
    chk({tag, "_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
    chk({tag, "_we"}, bus_if.bus_we, 1'b0);
    tick();
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_valid"}, rdata_valid, 1'b1);
    chk({tag, "_done_stall"}, stall, 1'b0);
    chk({tag, "_done_req"}, bus_if.bus_req, 1'b0);
    tick();
    mem_req = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_pulse"}, rdata_valid, 1'b0);
    chk({tag, "_rdata_hold"}, rdata, exp);
  endtask

  task automatic do_fault(input string tag, input logic [2:0] dm, input logic [31:0] a);
    tick();
    mem_req = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; DMType = dm; addr = a;
    @(negedge clk);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_fault_early"}, fault, 1'b0);
    tick();
    mem_req = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk({tag, "_fault"}, fault, 1'b1);
    chk({tag, "_req"}, bus_if.bus_req, 1'b0);
    tick();
    @(negedge clk);
    chk({tag, "_fault_pulse"}, fault, 1'b0);
    chk({tag, "_req_after"}, bus_if.bus_req, 1'b0);
  endtask

  initial begin
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'd0;

    tick();
    tick();
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bus_if.bus_req, 1'b0);
    chk("rst_we", bus_if.bus_we, 1'b0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    chk("rst_be", bus_if.bus_be, 4'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_valid", rdata_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);

    tick();
    rst = 1'b0;
    mem_req = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; DMType = DM_BYTE;
    addr = 32'h0000_1003; wdata = 32'h0000_00A5;
    @(negedge clk);
    chk("sb_accept_stall", stall, 1'b1);
    chk("sb_accept_req", bus_if.bus_req, 1'b0);
    tick();
    @(negedge clk);
    chk("sb_req", bus_if.bus_req, 1'b1);
    chk("sb_addr", bus_if.bus_addr, 32'h0000_1000);
    chk("sb_be", bus_if.bus_be, 4'b1000);
    chk("sb_wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
    chk("sb_we", bus_if.bus_we, 1'b1);
    chk("sb_busy1_stall", stall, 1'b1);
    tick();
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    chk("sb_busy2_stall", stall, 1'b1);
    chk("sb_busy2_req", bus_if.bus_req, 1'b1);
    chk("sb_busy2_addr", bus_if.bus_addr, 32'h0000_1000);
    tick();
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("sb_done_stall", stall, 1'b0);
    chk("sb_done_req", bus_if.bus_req, 1'b0);
    chk("sb_done_valid", rdata_valid, 1'b0);
    chk("sb_done_fault", fault, 1'b0);
    chk("sb_done_rdata", rdata, 32'd0);
    tick();
    mem_req = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("sb_idle_stall", stall, 1'b0);
    chk("sb_idle_req", bus_if.bus_req, 1'b0);
    chk("sb_idle_valid", rdata_valid, 1'b0);

    do_load("lh",  DM_HALF,   32'h0000_2002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    do_load("lbu", DM_BYTE_U, 32'h0000_2001, 32'h0000_F000, 4'b0010, 32'h0000_00F0);
    do_load("lb",  DM_BYTE,   32'h0000_2001, 32'h0000_F000, 4'b0010, 32'hFFFF_FFF0);
    do_load("lhu", DM_HALF_U, 32'h0000_2002, 32'h8001_1234, 4'b1100, 32'h0000_8001);
    do_load("lh0", DM_HALF,   32'h0000_2000, 32'h8001_1234, 4'b0011, 32'h0000_1234);

    do_fault("mis_w", DM_WORD, 32'h0000_3002);
    do_fault("mis_h", DM_HALF, 32'h0000_3001);
    do_fault("ill_dm", 3'b110, 32'h0000_3000);
    chk("fault_rdata_hold", rdata, 32'h0000_1234);

    tick();
    mem_req = 1'b1; MemRead = 1'b1; DMType = DM_WORD; addr = 32'h0000_0050;
    @(negedge clk);
    chk("rb_accept_stall", stall, 1'b1);
    tick();
    @(negedge clk);
    chk("rb_busy_req", bus_if.bus_req, 1'b1);
    tick();
    rst = 1'b1; mem_req = 1'b0; MemRead = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rb_req", bus_if.bus_req, 1'b0);
    chk("rb_stall", stall, 1'b0);
    tick();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rb_ack_req", bus_if.bus_req, 1'b0);
    tick();
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("rb_ack_valid", rdata_valid, 1'b0);
    chk("rb_ack_stall", stall, 1'b0);
    chk("rb_rdata", rdata, 32'd0);
    do_load("lw", DM_WORD, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    tick();
    mem_req = 1'b1; MemWrite = 1'b1; DMType = DM_WORD; addr = 32'h0000_0080; wdata = 32'h1234_5678;
    @(negedge clk);
    chk("to_accept_stall", stall, 1'b1);
    tick();
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_busy_req", bus_if.bus_req, 1'b1);
      tick();
    end
    mem_req = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("to_req_drop", bus_if.bus_req, 1'b0);
    chk("to_fault", fault, 1'b1);
    chk("to_stall", stall, 1'b0);
    chk("to_valid", rdata_valid, 1'b0);
`else
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("stuck_stall", stall, 1'b1);
    chk("stuck_req", bus_if.bus_req, 1'b1);
    chk("stuck_fault", fault, 1'b0);
    tick();
    rst = 1'b1; mem_req = 1'b0; MemWrite = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("stuck_rst_req", bus_if.bus_req, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_fsm.md
Name: lsu_fsm

Overview:
- Load/store unit sitting directly downstream of the main decoder's memory controls (MemWrite, MemRead, DMType).
- Converts one decoded load/store into a single word-aligned, byte-enabled bus transaction using a req/ack handshake.
- Stalls the pipeline until the access completes, then returns sign- or zero-extended load data.
- Flags misaligned accesses and illegal DMType values as faults; these produce no bus traffic.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, max BUSY cycles without bus_ack. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  in  1  EX stage holds a valid load/store.
- MemWrite  in  1  store when 1; takes priority if MemRead is also 1.
- MemRead  in  1  load.
- DMType  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101-111 illegal.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, LSB-justified.
- stall  out  1  freeze the pipeline.
- rdata  out  32  extended load result.
- rdata_valid  out  1  one-cycle pulse when rdata is valid.
- fault  out  1  one-cycle pulse on misalign, illegal DMType or timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  word-aligned address; addr[1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated write data.
- bus_ack  in  1  transaction complete; read data valid in the same cycle.
- bus_rdata  in  32  raw read word.

Behaviour:
- Reset: state IDLE; stall, rdata_valid, fault, bus_req, bus_we all 0; rdata, bus_addr, bus_be, bus_wdata all 0.
- States are IDLE, BUSY, DONE. A request is an access when mem_req is 1 and (MemWrite or MemRead) is 1.
- IDLE, access with legal DMType and aligned address:
  - Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
  - Latch bus_addr, bus_be, bus_wdata, bus_we, DMType and addr[1:0].
  - Next state BUSY.
  - stall=1 combinationally in this cycle.
- IDLE, access that is misaligned or has illegal DMType:
  - fault=1 in the next cycle; stays in IDLE; no bus_req.
  - stall=0, so the pipeline proceeds.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],0}
  - word: 1111
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- BUSY:
  - bus_req=1 and stall=1.
  - All bus_* outputs held stable until bus_ack is sampled high.
  - On ack: for a load, register the extracted lane into rdata; next state DONE.
  - bus_req drops in the cycle after ack.
- Load extract:
  - Select lane by the latched addr[1:0].
  - Sign-extend for types 011 and 001; zero-extend for 100 and 010.
  - Word passes through unchanged.
- DONE:
  - stall=0; rdata_valid=1 for a load, 0 for a store.
  - Next state IDLE unconditionally; mem_req in DONE is ignored.
- Latency: accept cycle, then BUSY until ack, then DONE. Minimum 3 cycles with a zero-wait ack.
- bus_ack outside BUSY is ignored.
- rst during BUSY: return to IDLE immediately, bus_req=0 in the next cycle, transaction abandoned.
- rdata holds its value until the next load completes.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - 8-bit cycle counter, cleared on BUSY entry and incremented each BUSY cycle.
  - When it reaches TIMEOUT with no ack: drop bus_req, pulse fault, go to DONE with rdata_valid=0.
- Undefined: no counter; BUSY waits indefinitely for bus_ack.

Decomposition:
- Package lsu_pkg holds:
  - DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U localparams, matching the decoder's DMType encoding.
  - State encoding IDLE/BUSY/DONE.
- Sub-module lsu_load_ext: combinational lane select plus sign/zero extension (inputs raw word, offset, DMType).

Test Plan:
- Store byte: DMType=011, addr=0x1003, wdata=0x000000A5, ack after 2 BUSY cycles → bus_addr=0x1000, bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1, stall high 3 cycles, rdata_valid stays 0.
- Signed load half: DMType=001, addr=0x2002, bus_rdata=0x8001_1234, zero-wait ack → bus_be=1100, rdata=0xFFFF8001, one rdata_valid pulse.
- Unsigned load byte: DMType=100, addr=0x2001, bus_rdata=0x0000_F000 → rdata=0x000000F0.
- Misaligned word: DMType=000, addr=0x3002 → fault pulse one cycle later, bus_req never asserted, stall=0; illegal DMType=110 gives the same result.
- Reset mid-BUSY: assert rst while bus_req=1 → bus_req=0, state IDLE, later bus_ack ignored; a following lw to 0x40 completes normally.
- LSU_TIMEOUT_EN with TIMEOUT=4 and no ack → bus_req drops after 4 BUSY cycles, fault pulse, stall released; without the macro, stall is still high after 1000 cycles.
